// File: rtl/wr_line_packer_if.sv
// Word-in / line-out bundle between an upstream word source, the packer and the memory controller write port.
interface wr_line_packer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 26,
  parameter int WORD_WIDTH = 32
);
  localparam int LB = $clog2(DATA_WIDTH / WORD_WIDTH);

  logic                     s_valid;
  logic                     s_ready;
  logic [ADDR_WIDTH+LB-1:0] s_addr;
  logic [WORD_WIDTH-1:0]    s_word;
  logic                     flush;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_busy;
  logic                     idle;
  logic [15:0]              partial_cnt;

  modport master (
    output s_valid, s_addr, s_word, flush, wr_busy,
    input  s_ready, wr_en, wr_addr, wr_data, idle, partial_cnt
  );

  modport slave (
    input  s_valid, s_addr, s_word, flush, wr_busy,
    output s_ready, wr_en, wr_addr, wr_data, idle, partial_cnt
  );
endinterface

// File: rtl/wr_line_packer.sv
// Packs addressed words into full controller lines; a completed line issues wr_en one cycle later when wr_busy is low.
// s_ready drops while the output buffer is full; WR_LINE_PACKER_TIMEOUT_EN adds an idle auto-close of the open line.
module wr_line_packer #(
  parameter int                    DATA_WIDTH = 128,
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] FILL_WORD  = '0,
  parameter int                    TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst,
  wr_line_packer_if.slave bus
);
  localparam int LANES = DATA_WIDTH / WORD_WIDTH;
  localparam int LB    = $clog2(LANES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } line_t;

  line_t            acc, acc_n, out_line, load_line;
  logic [LANES-1:0] acc_mask, mask_n, load_mask;
  logic             out_full, out_partial, flush_pending, pending_n, holdoff;
  logic             load, flush_req, flush_move, accept, acc_open, wr_en, tmo_flush;
  logic [15:0]      partial_cnt;
  logic [LB-1:0]    lane;
  logic [ADDR_WIDTH-1:0] s_line;

  assign acc_open = |acc_mask;
  assign accept   = bus.s_valid && !out_full;
  assign wr_en    = out_full && !bus.wr_busy && !holdoff;
  assign lane     = bus.s_addr[LB-1:0];
  assign s_line   = bus.s_addr[ADDR_WIDTH+LB-1:LB];

`ifdef WR_LINE_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (accept || !acc_open) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT - 1)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_flush = acc_open && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_flush = (TIMEOUT < 0);
`endif

  // Merge the accepted word first, then let a flush act on whatever line is left open.
  always_comb begin
    acc_n     = acc;
    mask_n    = acc_mask;
    load      = 1'b0;
    load_line = acc;
    load_mask = acc_mask;
    if (accept) begin
      if (acc_open && ((s_line != acc.addr) || acc_mask[lane])) begin
        load = 1'b1;
      end
      if (!acc_open || load) begin
        acc_n.data = {LANES{FILL_WORD}};
        mask_n     = '0;
      end
      acc_n.addr = s_line;
      acc_n.data[lane*WORD_WIDTH +: WORD_WIDTH] = bus.s_word;
      mask_n[lane] = 1'b1;
      // Only the new line can be complete here: a single word never fills LANES >= 2.
      if (&mask_n) begin
        load      = 1'b1;
        load_line = acc_n;
        load_mask = mask_n;
        mask_n    = '0;
      end
    end
    flush_req  = flush_pending || ((bus.flush || tmo_flush) && (|mask_n));
    flush_move = flush_req && (|mask_n) && !out_full && !load;
    if (flush_move) begin
      load      = 1'b1;
      load_line = acc_n;
      load_mask = mask_n;
      mask_n    = '0;
    end
    pending_n = flush_req && (|mask_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      acc_mask      <= '0;
      out_line      <= '0;
      out_full      <= 1'b0;
      out_partial   <= 1'b0;
      flush_pending <= 1'b0;
      holdoff       <= 1'b0;
      partial_cnt   <= '0;
    end else begin
      acc           <= acc_n;
      acc_mask      <= mask_n;
      flush_pending <= pending_n;
      holdoff       <= wr_en;
      if (load) begin
        out_line    <= load_line;
        out_partial <= ~&load_mask;
        out_full    <= 1'b1;
      end else if (wr_en) begin
        out_full    <= 1'b0;
      end
      if (wr_en && out_partial && (partial_cnt != 16'hFFFF)) begin
        partial_cnt <= partial_cnt + 16'd1;
      end
    end
  end

  assign bus.s_ready     = !out_full;
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = out_line.addr;
  assign bus.wr_data     = out_line.data;
  assign bus.idle        = !acc_open && !out_full && !flush_pending;
  assign bus.partial_cnt = partial_cnt;
endmodule

// File: tb/tb_wr_line_packer.sv
// Directed bench for wr_line_packer: 4 lanes of 32 bits, non-zero fill word, TIMEOUT=8.
module tb_wr_line_packer;
  localparam logic [31:0] FW = 32'hF111F111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  int   wr_cnt = 0;
  int   n0;
  int   k;
  logic [25:0]  last_addr = '0;
  logic [127:0] last_data = '0;

  wr_line_packer_if #(.DATA_WIDTH(128), .ADDR_WIDTH(26), .WORD_WIDTH(32)) bus ();

  wr_line_packer #(
    .DATA_WIDTH(128), .ADDR_WIDTH(26), .WORD_WIDTH(32), .FILL_WORD(FW), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Samples one time unit before each rising edge, after all negedge-driven inputs settle.
  always @(negedge clk) begin
    #4;
    if (!rst && bus.wr_en) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = bus.wr_addr;
      last_data = bus.wr_data;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [27:0] a, input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) chk("send_ready_timeout", bus.s_ready, 1);
    bus.s_valid = 1'b1;
    bus.s_addr  = a;
    bus.s_word  = w;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_addr  = '0;
    bus.s_word  = '0;
    bus.flush   = 1'b0;
    bus.wr_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_idle", bus.idle, 1);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_partial", bus.partial_cnt, 0);
    rst = 1'b0;

    // Full line at word addresses 0..3
    n0 = wr_cnt;
    send(28'd0, 32'd1);
    send(28'd1, 32'd2);
    send(28'd2, 32'd3);
    send(28'd3, 32'd4);
    chk("full_latency_wr_en", bus.wr_en, 1);
    chk("full_ready_low", bus.s_ready, 0);
    repeat (3) @(negedge clk);
    chk("full_count", wr_cnt - n0, 1);
    chk("full_addr", last_addr, 26'd0);
    chk("full_data", last_data, 128'h00000004_00000003_00000002_00000001);
    chk("full_partial", bus.partial_cnt, 0);
    chk("full_idle", bus.idle, 1);

    // Line change closes a partial line
    n0 = wr_cnt;
    send(28'd8, 32'hA);
    send(28'd12, 32'hB);
    repeat (3) @(negedge clk);
    chk("chg_count", wr_cnt - n0, 1);
    chk("chg_addr", last_addr, 26'd2);
    chk("chg_data", last_data, {FW, FW, FW, 32'h0000000A});
    chk("chg_partial", bus.partial_cnt, 1);
    chk("chg_line3_open", bus.idle, 0);
    pulse_flush();
    repeat (3) @(negedge clk);
    chk("chg_flush_addr", last_addr, 26'd3);
    chk("chg_flush_data", last_data, {FW, FW, FW, 32'h0000000B});
    chk("chg_flush_partial", bus.partial_cnt, 2);

    // Single word then flush
    n0 = wr_cnt;
    send(28'd5, 32'hC);
    pulse_flush();
    repeat (3) @(negedge clk);
    chk("fl_count", wr_cnt - n0, 1);
    chk("fl_addr", last_addr, 26'd1);
    chk("fl_data", last_data, {FW, FW, 32'h0000000C, FW});
    chk("fl_idle", bus.idle, 1);
    chk("fl_partial", bus.partial_cnt, 3);

    // Backpressure from the controller
    n0 = wr_cnt;
    bus.wr_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(28'(16 + i), 32'(16 + i));
    repeat (20) begin
      chk("busy_hold", {bus.s_ready, bus.wr_en}, 2'b00);
      @(negedge clk);
    end
    bus.wr_busy = 1'b0;
    #1;
    chk("busy_release_wr_en", bus.wr_en, 1);
    chk("busy_release_ready", bus.s_ready, 0);
    @(negedge clk);
    chk("busy_after_ready", bus.s_ready, 1);
    chk("busy_after_wr_en", bus.wr_en, 0);
    repeat (3) @(negedge clk);
    chk("busy_count", wr_cnt - n0, 1);
    chk("busy_addr", last_addr, 26'd4);
    chk("busy_data", last_data, 128'h00000013_00000012_00000011_00000010);
    chk("busy_partial", bus.partial_cnt, 3);

    // Rewriting a filled lane closes the line
    n0 = wr_cnt;
    send(28'd20, 32'h1);
    send(28'd20, 32'h2);
    pulse_flush();
    repeat (3) @(negedge clk);
    chk("relane_count", wr_cnt - n0, 2);
    chk("relane_addr", last_addr, 26'd5);
    chk("relane_data", last_data, {FW, FW, FW, 32'h00000002});
    chk("relane_partial", bus.partial_cnt, 5);

    // Word and flush in the same cycle
    n0 = wr_cnt;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_addr  = 28'd24;
    bus.s_word  = 32'h77;
    bus.flush   = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.flush   = 1'b0;
    chk("same_cycle_wr_en", bus.wr_en, 1);
    repeat (3) @(negedge clk);
    chk("same_cycle_count", wr_cnt - n0, 1);
    chk("same_cycle_data", last_data, {FW, FW, FW, 32'h00000077});
    chk("same_cycle_partial", bus.partial_cnt, 6);

    // Lone word with no flush
    n0 = wr_cnt;
    send(28'd28, 32'h99);
`ifdef WR_LINE_PACKER_TIMEOUT_EN
    k = 1;
    while (!bus.wr_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency_in_range", (k >= 8 && k <= 10), 1);
    repeat (3) @(negedge clk);
    chk("tmo_count", wr_cnt - n0, 1);
    chk("tmo_addr", last_addr, 26'd7);
`else
    k = 0;
    repeat (100) begin
      @(negedge clk);
      k++;
    end
    chk("no_tmo_count", wr_cnt - n0, 0);
    chk("no_tmo_open", bus.idle, 0);
`endif
    pulse_flush();
    repeat (3) @(negedge clk);
    chk("lone_total", wr_cnt - n0, 1);
    chk("lone_partial", bus.partial_cnt, 7);

    // Reset with a buffered line and an open line
    n0 = wr_cnt;
    bus.wr_busy = 1'b1;
    send(28'd32, 32'h1);
    send(28'd36, 32'h2);
    chk("prerst_ready", bus.s_ready, 0);
    chk("prerst_idle", bus.idle, 0);
    rst = 1'b1;
    bus.wr_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("inrst_wr_en", bus.wr_en, 0);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("postrst_count", wr_cnt - n0, 0);
    chk("postrst_idle", bus.idle, 1);
    chk("postrst_partial", bus.partial_cnt, 0);
    chk("postrst_ready", bus.s_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
